// File: rtl/mc_mem_if.sv
// Shared instruction/data memory handshake between the multi-cycle controller and memory.
// A request is outstanding while mem_req is high; it completes in the cycle where mem_ready is high.
interface mc_mem_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EXE/MEM/WB and drives datapath strobes.
// Strobes are combinational from state, IR fields, zero and mem_ready; state, counter and bus_err are registered.
module mc_controller #(
    parameter int ALUCTRL_W   = 3,
    parameter bit EN_BNEZALC  = 1'b1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_mem_if.master             mem,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic [4:0]           rt,
    input  logic                 zero,
    output logic [2:0]           state,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           wa_sel,
    output logic [1:0]           wd_sel,
    output logic                 alu_srcb,
    output logic                 ext_sign,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 instr_done,
    output logic                 illegal,
    output logic                 bus_err
);
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [4:0] RT_BNEZALC = 5'b10011;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_LUI = ALUCTRL_W'(4);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_J, C_JAL, C_JR, C_ILL, C_RALU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_BNEZ
    } cls_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 bus_err_q;
    cls_t                 cls;
    logic [ALUCTRL_W-1:0] r_alu, alu_sel;
    logic                 srcb_sel, sext_sel;
    logic                 wait_state, timeout_hit;

    // The IR is held by the datapath, so decode is valid and stable for the whole instruction.
    always_comb begin
        cls   = C_ILL;
        r_alu = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADDU: begin cls = C_RALU; r_alu = ALU_ADD; end
                    F_SUBU: begin cls = C_RALU; r_alu = ALU_SUB; end
                    F_OR:   begin cls = C_RALU; r_alu = ALU_OR;  end
                    F_JR:   cls = C_JR;
                    F_SLL:  cls = C_NOP;
                    default: cls = C_ILL;
                endcase
            end
            OP_REGIMM: cls = (EN_BNEZALC && rt == RT_BNEZALC) ? C_BNEZ : C_ILL;
            OP_J:      cls = C_J;
            OP_JAL:    cls = C_JAL;
            OP_BEQ:    cls = C_BEQ;
            OP_ORI:    cls = C_ORI;
            OP_LUI:    cls = C_LUI;
            OP_LW:     cls = C_LW;
            OP_SW:     cls = C_SW;
            default:   cls = C_ILL;
        endcase
    end

    always_comb begin
        alu_sel  = ALU_ADD;
        srcb_sel = 1'b0;
        sext_sel = 1'b0;
        case (cls)
            C_RALU:       alu_sel = r_alu;
            C_ORI:        begin alu_sel = ALU_OR;  srcb_sel = 1'b1; end
            C_LUI:        begin alu_sel = ALU_LUI; srcb_sel = 1'b1; end
            C_LW, C_SW:   begin alu_sel = ALU_ADD; srcb_sel = 1'b1; sext_sel = 1'b1; end
            C_BEQ, C_BNEZ: begin alu_sel = ALU_SUB; sext_sel = 1'b1; end
            default:      alu_sel = ALU_ADD;
        endcase
    end

    // A late mem_ready on the timeout cycle still completes the access.
    assign wait_state  = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout_hit = (MEM_TIMEOUT > 0) && wait_state && !mem.mem_ready &&
                         (cnt_q == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        reg_write   = 1'b0;
        wa_sel      = 2'd0;
        wd_sel      = 2'd0;
        alu_srcb    = 1'b0;
        ext_sign    = 1'b0;
        alu_ctrl    = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
            alu_ctrl = alu_sel;
            alu_srcb = srcb_sel;
            ext_sign = sext_sel;
        end
        case (state_q)
            S_IF: begin
                if (timeout_hit) begin
                    state_d = S_IF;
                end else begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
            end
            S_ID: begin
                case (cls)
                    C_NOP: begin instr_done = 1'b1; state_d = S_IF; end
                    C_J:   begin pc_write = 1'b1; pc_src = 2'd2; instr_done = 1'b1; state_d = S_IF; end
                    C_JAL: begin
                        pc_write = 1'b1; pc_src = 2'd2;
                        reg_write = 1'b1; wa_sel = 2'd2; wd_sel = 2'd2;
                        instr_done = 1'b1; state_d = S_IF;
                    end
                    C_JR:  begin pc_write = 1'b1; pc_src = 2'd3; instr_done = 1'b1; state_d = S_IF; end
                    C_ILL: begin illegal = 1'b1; instr_done = 1'b1; state_d = S_IF; end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls)
                    C_BEQ: begin
                        if (zero) begin pc_write = 1'b1; pc_src = 2'd1; end
                        instr_done = 1'b1; state_d = S_IF;
                    end
                    C_BNEZ: begin
                        reg_write = 1'b1; wa_sel = 2'd2; wd_sel = 2'd2;
                        if (!zero) begin pc_write = 1'b1; pc_src = 2'd1; end
                        instr_done = 1'b1; state_d = S_IF;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (timeout_hit) begin
                    state_d = S_IF;
                end else begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = (cls == C_SW);
                    if (mem.mem_ready) begin
                        if (cls == C_SW) begin
                            instr_done = 1'b1;
                            state_d    = S_IF;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wa_sel     = (cls == C_RALU) ? 2'd1 : 2'd0;
                wd_sel     = (cls == C_LW) ? 2'd1 : 2'd0;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase
        if (reset) begin
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'd0;
            reg_write   = 1'b0;
            wa_sel      = 2'd0;
            wd_sel      = 2'd0;
            alu_srcb    = 1'b0;
            ext_sign    = 1'b0;
            alu_ctrl    = ALU_ADD;
            instr_done  = 1'b0;
            illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timeout_hit) bus_err_q <= 1'b1;
            if (MEM_TIMEOUT == 0 || state_d != state_q || timeout_hit) begin
                cnt_q <= '0;
            end else if (wait_state && !mem.mem_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: two instances (no-timeout with bnezalc, timeout=4 without bnezalc)
// compared cycle by cycle against per-instruction expected output sequences built from the ISA rules.
module tb_mc_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int I_ADDU = 0, I_SUBU = 1, I_OR = 2, I_ORI = 3, I_LUI = 4, I_LW = 5, I_SW = 6;
  localparam int I_BEQ = 7, I_J = 8, I_JAL = 9, I_JR = 10, I_NOP = 11, I_BNEZ = 12, I_ILL = 13;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wa_sel;
    logic [1:0] wd_sel;
    logic       alu_srcb;
    logic       ext_sign;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } rec_t;

  typedef struct packed {
    logic mr;
    logic z;
    rec_t r;
  } ent_t;

  localparam int ENT_W = $bits(ent_t);

  logic       rst_v[2];
  logic [5:0] op_v[2];
  logic [5:0] func_v[2];
  logic [4:0] rt_v[2];
  logic       mr_v[2];
  logic       z_v[2];
  rec_t       obs[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_mem_if bus();
    logic [2:0] state;
    logic       ir_write, pc_write, reg_write, alu_srcb, ext_sign, instr_done, illegal, bus_err;
    logic [1:0] pc_src, wa_sel, wd_sel;
    logic [2:0] alu_ctrl;

    assign bus.mem_ready = mr_v[g];

    mc_controller #(
      .ALUCTRL_W  (3),
      .EN_BNEZALC (g == 0),
      .MEM_TIMEOUT(g == 0 ? 0 : 4)
    ) dut (
      .clk       (clk),
      .reset     (rst_v[g]),
      .mem       (bus),
      .op        (op_v[g]),
      .func      (func_v[g]),
      .rt        (rt_v[g]),
      .zero      (z_v[g]),
      .state     (state),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .reg_write (reg_write),
      .wa_sel    (wa_sel),
      .wd_sel    (wd_sel),
      .alu_srcb  (alu_srcb),
      .ext_sign  (ext_sign),
      .alu_ctrl  (alu_ctrl),
      .instr_done(instr_done),
      .illegal   (illegal),
      .bus_err   (bus_err)
    );

    assign obs[g] = {state, bus.mem_req, bus.mem_we, ir_write, pc_write, pc_src, reg_write,
                     wa_sel, wd_sel, alu_srcb, ext_sign, alu_ctrl, instr_done, illegal, bus_err};
  end

  int         n_chk = 0;
  int         n_err = 0;
  bit         m_bus[2];
  int         tmo_of[2] = '{0, 4};
  bit         en_of[2] = '{1'b1, 1'b0};
  logic [ENT_W-1:0] exp_q[$];
  string      tag;
  string      nm[14] = '{"addu", "subu", "or", "ori", "lui", "lw", "sw",
                         "beq", "j", "jal", "jr", "nop", "bnezalc", "illegal"};

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", t, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic rec_t base(input int d, input logic [2:0] s);
    rec_t r;
    r = '0;
    r.state   = s;
    r.bus_err = m_bus[d];
    return r;
  endfunction

  task automatic push(input logic mr, input logic z, input rec_t r);
    ent_t e;
    e.mr = mr;
    e.z  = z;
    e.r  = r;
    exp_q.push_back(e);
  endtask

  // ALU operation, operand-B select and immediate extension each instruction uses from EXE on.
  task automatic alu_of(input int k, inout rec_t r);
    case (k)
      I_SUBU:       r.alu_ctrl = 3'd1;
      I_OR:         r.alu_ctrl = 3'd3;
      I_ORI:        begin r.alu_ctrl = 3'd3; r.alu_srcb = 1'b1; end
      I_LUI:        begin r.alu_ctrl = 3'd4; r.alu_srcb = 1'b1; end
      I_LW, I_SW:   begin r.alu_ctrl = 3'd0; r.alu_srcb = 1'b1; r.ext_sign = 1'b1; end
      I_BEQ, I_BNEZ: begin r.alu_ctrl = 3'd1; r.ext_sign = 1'b1; end
      default:      r.alu_ctrl = 3'd0;
    endcase
  endtask

  task automatic enc(input int k, input int d);
    op_v[d]   = 6'd0;
    func_v[d] = 6'($urandom);
    rt_v[d]   = 5'($urandom);
    case (k)
      I_ADDU: func_v[d] = 6'b100001;
      I_SUBU: func_v[d] = 6'b100011;
      I_OR:   func_v[d] = 6'b100101;
      I_JR:   func_v[d] = 6'b001000;
      I_NOP:  begin func_v[d] = 6'd0; rt_v[d] = 5'd0; end
      I_ORI:  op_v[d] = 6'b001101;
      I_LUI:  op_v[d] = 6'b001111;
      I_LW:   op_v[d] = 6'b100011;
      I_SW:   op_v[d] = 6'b101011;
      I_BEQ:  op_v[d] = 6'b000100;
      I_J:    op_v[d] = 6'b000010;
      I_JAL:  op_v[d] = 6'b000011;
      I_BNEZ: begin op_v[d] = 6'b000001; rt_v[d] = 5'b10011; end
      default: begin
        case ($urandom_range(0, 2))
          0:       op_v[d] = 6'b111111;
          1:       func_v[d] = 6'b101010;
          default: begin op_v[d] = 6'b000001; rt_v[d] = 5'b00001; end
        endcase
      end
    endcase
  endtask

  // Expected cycle sequence for one instruction: wif/wmem are mem_ready-low cycles before completion.
  task automatic gen(input int d, input int kind, input int wif, input int wmem, input logic z);
    rec_t r;
    int   k;
    int   t;
    k = kind;
    t = tmo_of[d];
    if (k == I_BNEZ && !en_of[d]) k = I_ILL;
    for (int i = 0; i <= wif; i++) begin
      r = base(d, 3'd0);
      if (t > 0 && i == t && i < wif) begin
        push(1'b0, rb(), r);
        m_bus[d] = 1'b1;
        return;
      end
      r.mem_req = 1'b1;
      if (i == wif) begin
        r.ir_write = 1'b1;
        r.pc_write = 1'b1;
        push(1'b1, rb(), r);
      end else begin
        push(1'b0, rb(), r);
      end
    end
    r = base(d, 3'd1);
    case (k)
      I_NOP: r.instr_done = 1'b1;
      I_J:   begin r.pc_write = 1'b1; r.pc_src = 2'd2; r.instr_done = 1'b1; end
      I_JAL: begin
        r.pc_write = 1'b1; r.pc_src = 2'd2; r.reg_write = 1'b1;
        r.wa_sel = 2'd2; r.wd_sel = 2'd2; r.instr_done = 1'b1;
      end
      I_JR:  begin r.pc_write = 1'b1; r.pc_src = 2'd3; r.instr_done = 1'b1; end
      I_ILL: begin r.illegal = 1'b1; r.instr_done = 1'b1; end
      default: ;
    endcase
    push(rb(), rb(), r);
    if (r.instr_done) return;
    r = base(d, 3'd2);
    alu_of(k, r);
    if (k == I_BEQ || k == I_BNEZ) begin
      if (k == I_BNEZ) begin
        r.reg_write = 1'b1; r.wa_sel = 2'd2; r.wd_sel = 2'd2;
      end
      if ((k == I_BEQ) == z) begin
        r.pc_write = 1'b1; r.pc_src = 2'd1;
      end
      r.instr_done = 1'b1;
      push(rb(), z, r);
      return;
    end
    push(rb(), z, r);
    if (k == I_LW || k == I_SW) begin
      for (int i = 0; i <= wmem; i++) begin
        r = base(d, 3'd3);
        alu_of(k, r);
        if (t > 0 && i == t && i < wmem) begin
          push(1'b0, rb(), r);
          m_bus[d] = 1'b1;
          return;
        end
        r.mem_req = 1'b1;
        r.mem_we  = (k == I_SW);
        if (i < wmem) begin
          push(1'b0, rb(), r);
        end else begin
          r.instr_done = (k == I_SW);
          push(1'b1, rb(), r);
          if (k == I_SW) return;
        end
      end
    end
    r = base(d, 3'd4);
    alu_of(k, r);
    r.reg_write  = 1'b1;
    r.wa_sel     = (k == I_ADDU || k == I_SUBU || k == I_OR) ? 2'd1 : 2'd0;
    r.wd_sel     = (k == I_LW) ? 2'd1 : 2'd0;
    r.instr_done = 1'b1;
    push(rb(), rb(), r);
  endtask

  task automatic step(input int d);
    ent_t e;
    e = exp_q.pop_front();
    mr_v[d] = e.mr;
    z_v[d]  = e.z;
    @(negedge clk);
    check(tag, 32'(obs[d]), 32'(e.r));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int d, input int k, input int wif, input int wmem, input logic z);
    tag = $sformatf("d%0d %s", d, nm[k]);
    enc(k, d);
    gen(d, k, wif, wmem, z);
    while (exp_q.size() > 0) step(d);
  endtask

  initial begin
    ent_t e;
    rst_v  = '{1'b1, 1'b1};
    op_v   = '{6'd0, 6'd0};
    func_v = '{6'd0, 6'd0};
    rt_v   = '{5'd0, 5'd0};
    mr_v   = '{1'b1, 1'b1};
    z_v    = '{1'b0, 1'b0};
    m_bus  = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("d0 reset outputs", 32'(obs[0]), 32'd0);
    check("d1 reset outputs", 32'(obs[1]), 32'd0);
    rst_v[0] = 1'b0;

    run(0, I_ADDU, 0, 0, 1'b0);
    run(0, I_LW, 0, 2, 1'b0);
    run(0, I_BEQ, 0, 0, 1'b1);
    run(0, I_BEQ, 0, 0, 1'b0);
    run(0, I_BNEZ, 0, 0, 1'b0);
    run(0, I_BNEZ, 0, 0, 1'b1);
    for (int k = 0; k < 14; k++) run(0, k, 1, 1, rb());
    for (int n = 0; n < 200; n++)
      run(0, $urandom_range(0, 13), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    // Asynchronous reset in the WB cycle of a load.
    tag = "d0 lw before reset";
    enc(I_LW, 0);
    gen(0, I_LW, 0, 0, rb());
    for (int i = 0; i < 4; i++) step(0);
    e = exp_q.pop_front();
    exp_q.delete();
    mr_v[0] = e.mr;
    z_v[0]  = e.z;
    #1;
    check("d0 lw wb before reset", 32'(obs[0]), 32'(e.r));
    rst_v[0] = 1'b1;
    #1;
    check("d0 async reset in wb", 32'(obs[0]), 32'd0);
    @(posedge clk);
    #1;
    check("d0 reset held", 32'(obs[0]), 32'd0);
    rst_v[0] = 1'b0;
    m_bus[0] = 1'b0;
    for (int n = 0; n < 10; n++)
      run(0, $urandom_range(0, 13), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    rst_v[0] = 1'b1;
    rst_v[1] = 1'b0;
    run(1, I_BNEZ, 0, 0, 1'b0);
    run(1, I_ADDU, 0, 0, 1'b0);
    run(1, I_SW, 0, 8, 1'b0);
    run(1, I_ADDU, 0, 0, 1'b0);
    run(1, I_LW, 4, 4, 1'b0);
    run(1, I_J, 6, 0, 1'b0);
    run(1, I_SW, 2, 3, 1'b0);
    for (int n = 0; n < 80; n++)
      run(1, $urandom_range(0, 13), $urandom_range(0, 6), $urandom_range(0, 6), rb());
    rst_v[1] = 1'b1;
    #1;
    check("d1 reset clears bus_err", 32'(obs[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_v[1] = 1'b0;
    m_bus[1] = 1'b0;
    run(1, I_ORI, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
